// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns the EX/MEM bundle into a req/ack data-memory
// transaction (or a pass-through), stalls upstream while busy, and drives MEM/WB.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_RegWrite_o,
    output logic [4:0]  wb_RDaddr_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          cap_regwrite;
    logic [4:0]    cap_rd;

    logic mem_op;
    logic legal;
    logic timed_out;

    assign mem_op    = MemRead_i | MemWrite_i;
    assign legal     = (MemRead_i ^ MemWrite_i) & (addr_i[1:0] == 2'b00);
    assign timed_out = (cnt == CNT_MAX);

    // Upstream holds while a request is being launched or is still waiting;
    // the cycle that resolves the transaction (ack or abort) releases it.
    assign stall_o = ((state == IDLE) & valid_i & legal)
                   | ((state == BUSY) & ~mem_ack_i & ~timed_out);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            cap_regwrite  <= 1'b0;
            cap_rd        <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            wb_valid_o    <= 1'b0;
            wb_RegWrite_o <= 1'b0;
            wb_RDaddr_o   <= '0;
            wb_data_o     <= '0;
            err_o         <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (legal) begin
                            state        <= BUSY;
                            cnt          <= '0;
                            mem_req_o    <= 1'b1;
                            mem_we_o     <= MemWrite_i;
                            mem_addr_o   <= addr_i;
                            mem_wdata_o  <= wdata_i;
                            cap_regwrite <= RegWrite_i;
                            cap_rd       <= RDaddr_i;
                        end else begin
                            // Pass-through, or a rejected (misaligned/ambiguous) access.
                            wb_valid_o    <= 1'b1;
                            wb_RegWrite_o <= mem_op ? 1'b0 : RegWrite_i;
                            wb_RDaddr_o   <= RDaddr_i;
                            wb_data_o     <= addr_i;
                            err_o         <= mem_op;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state         <= IDLE;
                        mem_req_o     <= 1'b0;
                        wb_valid_o    <= 1'b1;
                        wb_RegWrite_o <= ~mem_we_o & cap_regwrite;
                        wb_RDaddr_o   <= cap_rd;
                        wb_data_o     <= mem_we_o ? mem_addr_o : mem_rdata_i;
                    end else if (timed_out) begin
                        state         <= IDLE;
                        mem_req_o     <= 1'b0;
                        wb_valid_o    <= 1'b1;
                        wb_RegWrite_o <= 1'b0;
                        err_o         <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized scoreboard bench for mem_stage_ctrl: the driver predicts each
// write-back bundle and its arrival cycle; a monitor pops and compares them.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 4;
    localparam int NOACK   = TIMEOUT + 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, MemRead_i, MemWrite_i, RegWrite_i, mem_ack_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic [4:0]  RDaddr_i;
    logic        mem_req_o, mem_we_o, stall_o, wb_valid_o, wb_RegWrite_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic [4:0]  wb_RDaddr_o;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .RegWrite_i(RegWrite_i), .RDaddr_i(RDaddr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o),
        .wb_RegWrite_o(wb_RegWrite_o), .wb_RDaddr_o(wb_RDaddr_o),
        .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic        payload;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write-back pulse must match the oldest prediction.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i === 1'b0) chk("err_without_wb", {31'd0, err_o & ~wb_valid_o}, 32'd0);
        if (wb_valid_o === 1'b1) begin
            chk("wb_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wb_cycle", cyc, e.cyc);
                chk("wb_RegWrite", {31'd0, wb_RegWrite_o}, {31'd0, e.rw});
                chk("wb_err", {31'd0, err_o}, {31'd0, e.err});
                if (e.payload) begin
                    chk("wb_RDaddr", {27'd0, wb_RDaddr_o}, {27'd0, e.rd});
                    chk("wb_data", wb_data_o, e.data);
                end
            end
        end
    end

    // kind: 0 non-memory, 1 load, 2 store, 3 both flags set.
    // k: cycle (1..TIMEOUT+1) in which memory acks; NOACK means never.
    task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rw, input logic [4:0] rd, input int k,
                         input logic [31:0] rdat);
        exp_t        e;
        int unsigned c0;
        logic        legal;
        @(posedge clk_i); #1;
        valid_i    = 1'b1;
        MemRead_i  = (kind == 1 || kind == 3);
        MemWrite_i = (kind == 2 || kind == 3);
        addr_i     = addr;
        wdata_i    = wd;
        RegWrite_i = rw;
        RDaddr_i   = rd;
        mem_ack_i  = 1'b0;
        c0         = cyc;
        legal      = (kind == 1 || kind == 2) && (addr[1:0] == 2'b00);
        if (!legal) begin
            e = '{c0 + 1, (kind == 0) ? rw : 1'b0, rd, addr, kind != 0, 1'b1};
            q.push_back(e);
        end
        @(negedge clk_i);
        chk("stall_accept", {31'd0, stall_o}, {31'd0, legal});
        chk("req_idle", {31'd0, mem_req_o}, 32'd0);
        if (legal) begin
            for (int i = 1; i <= TIMEOUT + 1; i++) begin
                @(posedge clk_i); #1;
                mem_ack_i   = (i == k);
                mem_rdata_i = (i == k) ? rdat : $urandom;
                if (i == k) begin
                    e = '{c0 + k + 1, (kind == 1) ? rw : 1'b0, rd, (kind == 1) ? rdat : addr, 1'b0, 1'b1};
                    q.push_back(e);
                end else if (i == TIMEOUT + 1) begin
                    e = '{c0 + TIMEOUT + 2, 1'b0, rd, 32'd0, 1'b1, 1'b0};
                    q.push_back(e);
                end
                @(negedge clk_i);
                chk("req_busy", {31'd0, mem_req_o}, 32'd1);
                chk("we_busy", {31'd0, mem_we_o}, {31'd0, kind == 2});
                chk("addr_busy", mem_addr_o, addr);
                chk("wdata_busy", mem_wdata_o, wd);
                chk("stall_busy", {31'd0, stall_o}, {31'd0, (i != k) && (i != TIMEOUT + 1)});
                if (i == k) break;
            end
        end
    endtask

    task automatic idle(input int n, input logic stray_ack);
        repeat (n) begin
            @(posedge clk_i); #1;
            valid_i     = 1'b0;
            mem_ack_i   = stray_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata_i = $urandom;
            @(negedge clk_i);
            chk("stall_idle", {31'd0, stall_o}, 32'd0);
            chk("req_idle", {31'd0, mem_req_o}, 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd0);
        chk({tag, "_wb_rw"}, {31'd0, wb_RegWrite_o}, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, wb_RDaddr_o}, 32'd0);
        chk({tag, "_wb_data"}, wb_data_o, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cycle %0d reached, required completion earlier", cyc);
        $fatal(1);
    end

    initial begin
        int          kind;
        logic [31:0] a;
        rst_i = 1'b1; valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = '0; wdata_i = '0; RegWrite_i = 1'b0; RDaddr_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Directed cases.
        issue(0, 32'h0000_002A, 32'd0, 1'b1, 5'd5, 0, 32'd0);
        issue(1, 32'h0000_0100, 32'd0, 1'b1, 5'd7, 1, 32'hDEAD_BEEF);
        issue(2, 32'h0000_0204, 32'h0000_1234, 1'b1, 5'd9, 5, 32'd0);
        issue(1, 32'h0000_0102, 32'd0, 1'b1, 5'd3, 0, 32'd0);
        issue(3, 32'h0000_0200, 32'd0, 1'b1, 5'd4, 0, 32'd0);
        issue(1, 32'h0000_0300, 32'd0, 1'b1, 5'd6, NOACK, 32'd0);
        issue(1, 32'h0000_0304, 32'd0, 1'b1, 5'd8, TIMEOUT, 32'hCAFE_F00D);
        idle(3, 1'b1);

        // Reset in the middle of a pending load; a later ack must be ignored.
        @(posedge clk_i); #1;
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        addr_i = 32'h0000_0400; RegWrite_i = 1'b1; RDaddr_i = 5'd10;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_pre_req", {31'd0, mem_req_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; valid_i = 1'b0;
        @(negedge clk_i);
        chk_all_zero("midrst");
        @(posedge clk_i); #1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        @(negedge clk_i);
        chk("midrst_ack_req", {31'd0, mem_req_o}, 32'd0);
        chk("midrst_ack_stall", {31'd0, stall_o}, 32'd0);
        idle(3, 1'b0);

        // Randomized traffic with stray acks in idle gaps.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 4);
            a    = $urandom;
            if (kind == 4) begin
                kind = $urandom_range(1, 2);
                a[1:0] = 2'($urandom_range(1, 3));
            end else if (kind == 1 || kind == 2) begin
                a[1:0] = 2'b00;
            end
            issue(kind, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(1, NOACK), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
        end

        idle(4, 1'b0);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
